// File: rtl/cfg_regfile.sv
// Shadow/active config registers with atomic commit, sticky W1C status and masked irq.
// Read data, err, pending and irq all appear one cycle after cause; no backpressure, one access per cycle.
module cfg_regfile #(
    parameter int NUM_CFG    = 2,
    parameter int NUM_STATUS = 1,
    parameter int DATA_WIDTH = 8,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_RESET = '0,
    parameter logic [NUM_CFG*DATA_WIDTH-1:0] CFG_WMASK = '1,
    localparam int AW = (NUM_CFG + NUM_STATUS > 1) ? $clog2(NUM_CFG + NUM_STATUS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic                             we_i,
    input  logic [AW-1:0]                    addr_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             rvalid_o,
    output logic                             err_o,
    input  logic                             commit_i,
    output logic                             pending_o,
    input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_set_i,
    input  logic [NUM_STATUS*DATA_WIDTH-1:0] irq_mask_i,
    output logic                             irq_o,
    output logic [NUM_CFG*DATA_WIDTH-1:0]    cfg_o
);

    localparam int NUM_REGS = NUM_CFG + NUM_STATUS;
    localparam int DW       = DATA_WIDTH;

    logic [NUM_CFG*DW-1:0]    shadow_q, shadow_d;
    logic [NUM_CFG*DW-1:0]    active_q, active_d;
    logic [NUM_STATUS*DW-1:0] sticky_q, sticky_d;
    logic [DW-1:0]            data_q, data_d;
    logic                     rvalid_q, rvalid_d;
    logic                     err_q, err_d;
    logic                     pending_q, pending_d;
    logic                     irq_q, irq_d;

    logic [31:0] addr_ext;
    logic        wr, rd, in_range;

    assign addr_ext = 32'(addr_i);
    assign wr       = en_i & we_i;
    assign rd       = en_i & ~we_i;
    // Compare in 32 bits so non-power-of-two maps never alias onto real registers.
    assign in_range = addr_ext < 32'(NUM_REGS);

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        sticky_d  = sticky_q | status_set_i;
        data_d    = data_q;
        rvalid_d  = rd;
        err_d     = en_i & ~in_range;
        pending_d = (shadow_q != active_q);
        irq_d     = |(sticky_q & irq_mask_i);

        // Commit samples the pre-write shadow, so a same-cycle write stays pending.
        if (commit_i) begin
            active_d = shadow_q;
        end

        if (rd) begin
            data_d = '0;
        end

        for (int k = 0; k < NUM_CFG; k++) begin
            if (addr_ext == 32'(k)) begin
                if (wr) begin
                    shadow_d[k*DW +: DW] = (shadow_q[k*DW +: DW] & ~CFG_WMASK[k*DW +: DW])
                                         | (data_i & CFG_WMASK[k*DW +: DW]);
                end
                if (rd) begin
                    data_d = shadow_q[k*DW +: DW];
                end
            end
        end

        for (int j = 0; j < NUM_STATUS; j++) begin
            if (addr_ext == 32'(NUM_CFG + j)) begin
                if (wr) begin
                    sticky_d[j*DW +: DW] = (sticky_q[j*DW +: DW] & ~data_i)
                                         | status_set_i[j*DW +: DW];
                end
                if (rd) begin
                    data_d = sticky_q[j*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q  <= CFG_RESET;
            active_q  <= CFG_RESET;
            sticky_q  <= '0;
            data_q    <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            sticky_q  <= sticky_d;
            data_q    <= data_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign data_o    = data_q;
    assign rvalid_o  = rvalid_q;
    assign err_o     = err_q;
    assign pending_o = pending_q;
    assign irq_o     = irq_q;
    assign cfg_o     = active_q;

endmodule

// File: tb/tb_cfg_regfile.sv
// Directed bench for cfg_regfile: reset, shadow/commit, write mask, sticky W1C/irq, out-of-range, reset mid-op.
module tb_cfg_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, we, commit;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rvalid, err, pending, irq;
    logic [7:0]  set, mask;
    logic [15:0] cfg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfg_regfile #(
        .NUM_CFG   (2),
        .NUM_STATUS(1),
        .DATA_WIDTH(8),
        .CFG_RESET (16'h0A05),
        .CFG_WMASK (16'hFF03)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .we_i        (we),
        .addr_i      (addr),
        .data_i      (wdata),
        .data_o      (rdata),
        .rvalid_o    (rvalid),
        .err_o       (err),
        .commit_i    (commit),
        .pending_o   (pending),
        .status_set_i(set),
        .irq_mask_i  (mask),
        .irq_o       (irq),
        .cfg_o       (cfg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en = 1'b0; we = 1'b0; commit = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rd_acc(input logic [1:0] a);
        en = 1'b1; we = 1'b0; addr = a;
    endtask

    task automatic wr_acc(input logic [1:0] a, input logic [7:0] d);
        en = 1'b1; we = 1'b1; addr = a; wdata = d;
    endtask

    initial begin
        rst_n = 1'b0; set = '0; mask = '0;
        idle();
        step(); step();
        rst_n = 1'b1;
        chk("rst_cfg", cfg, 16'h0A05);
        chk("rst_data", rdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_irq", irq, 0);
        chk("rst_pending", pending, 0);

        rd_acc(2'd1); step(); idle();
        chk("rd1_data", rdata, 8'h0A);
        chk("rd1_rvalid", rvalid, 1);
        chk("rd1_err", err, 0);
        step();
        chk("rvalid_pulse", rvalid, 0);
        chk("data_hold", rdata, 8'h0A);

        wr_acc(2'd1, 8'h3C); step(); idle();
        chk("wr_cfg_unchanged", cfg, 16'h0A05);
        chk("wr_no_rvalid", rvalid, 0);
        chk("pending_lag", pending, 0);
        step();
        chk("pending_set", pending, 1);
        commit = 1'b1; step(); idle();
        chk("commit_cfg", cfg, 16'h3C05);
        chk("pending_still", pending, 1);
        step();
        chk("pending_clear", pending, 0);

        wr_acc(2'd0, 8'hFF); step();
        rd_acc(2'd0); step(); idle();
        chk("wmask_ff", rdata, 8'h07);
        wr_acc(2'd0, 8'h00); step();
        rd_acc(2'd0); step(); idle();
        chk("wmask_00", rdata, 8'h04);
        wr_acc(2'd0, 8'h03); step(); idle();
        commit = 1'b1; step(); idle(); step();
        chk("commit2_cfg", cfg, 16'h3C07);
        chk("pending_clean", pending, 0);

        wr_acc(2'd1, 8'h01); step();
        wr_acc(2'd1, 8'h02); commit = 1'b1; step(); idle();
        chk("simul_cfg", cfg, 16'h0107);
        step();
        chk("simul_pending", pending, 1);
        rd_acc(2'd1); step(); idle();
        chk("simul_shadow", rdata, 8'h02);

        mask = 8'h10; set = 8'h10; step(); set = '0;
        chk("irq_lag", irq, 0);
        step();
        chk("irq_set", irq, 1);
        rd_acc(2'd2); set = 8'h01; step(); idle(); set = '0;
        chk("sticky_pre_set", rdata, 8'h10);
        rd_acc(2'd2); step(); idle();
        chk("sticky_accum", rdata, 8'h11);
        wr_acc(2'd2, 8'h11); set = 8'h10; step(); idle(); set = '0;
        rd_acc(2'd2); step(); idle();
        chk("w1c_set_wins", rdata, 8'h10);
        chk("irq_held", irq, 1);
        wr_acc(2'd2, 8'h10); step(); idle();
        chk("irq_drop_lag", irq, 1);
        step();
        chk("irq_dropped", irq, 0);
        rd_acc(2'd2); step(); idle();
        chk("sticky_cleared", rdata, 8'h00);

        rd_acc(2'd0); step();
        rd_acc(2'd3); step(); idle();
        chk("oor_rd_err", err, 1);
        chk("oor_rd_rvalid", rvalid, 1);
        chk("oor_rd_data", rdata, 8'h00);
        wr_acc(2'd3, 8'hFF); step(); idle();
        chk("oor_wr_err", err, 1);
        chk("oor_wr_rvalid", rvalid, 0);
        step();
        chk("err_pulse", err, 0);
        chk("oor_cfg", cfg, 16'h0107);
        rd_acc(2'd0); step();
        rd_acc(2'd2); idle(); rd_acc(2'd2); step(); idle();
        chk("oor_sticky", rdata, 8'h00);

        set = 8'h10; step(); set = '0;
        wr_acc(2'd0, 8'h02); commit = 1'b1; rst_n = 1'b0; set = 8'h10; step();
        rst_n = 1'b1; idle(); set = '0;
        chk("midrst_cfg", cfg, 16'h0A05);
        chk("midrst_pending", pending, 0);
        chk("midrst_irq", irq, 0);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_data", rdata, 0);
        step();
        chk("midrst_pending2", pending, 0);
        chk("midrst_irq2", irq, 0);
        rd_acc(2'd0); step(); idle();
        chk("midrst_shadow0", rdata, 8'h05);
        rd_acc(2'd2); step(); idle();
        chk("midrst_sticky", rdata, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
